// File: rtl/bsg_tag_packet_decoder.sv
//------------------------------------------------------------------------------
// bsg_tag_packet_decoder
//
// Serial receiver for the bsg_tag bit stream. Samples the one-bit tag data
// line every tag clock, recovers the packet header (node id, data_not_reset,
// len) and the payload, and presents each good packet as one parallel word
// behind a valid/yumi handshake.
//
// Wire order (multi-bit fields LSB first):
//   start(1) | node id(lg_els_lp) | data_not_reset(1) | len(lg_width_p) |
//   payload(len) | parity(1, only with BSG_TAG_PACKET_DECODER_PARITY_EN)
//
// Optional feature macro: BSG_TAG_PACKET_DECODER_PARITY_EN
//   When defined, one even-parity bit over node id, data_not_reset, len and
//   payload follows the payload; a mismatch drops the packet with error_o.
//
// Ports:
//   clk_i             tag clock, everything samples on posedge
//   reset_i           asynchronous, active-high reset
//   data_i            serial tag data
//   valid_o           a decoded packet is held on the outputs
//   yumi_i            consumer takes the held packet (only while valid_o)
//   node_id_o         node id of the held packet
//   data_not_reset_o  1 = data packet, 0 = client reset packet
//   len_o             payload length of the held packet
//   payload_o         payload, right-aligned, upper bits zero
//   error_o           one-cycle pulse: malformed packet dropped
//   overflow_o        one-cycle pulse: good packet dropped, output full
//------------------------------------------------------------------------------
module bsg_tag_packet_decoder #(
   parameter int els_p               = 64,
   parameter int lg_width_p          = 4,
   parameter int max_payload_width_p = 10,
   localparam int lg_els_lp          = $clog2(els_p)
) (
   input  logic                           clk_i,
   input  logic                           reset_i,
   input  logic                           data_i,
   output logic                           valid_o,
   input  logic                           yumi_i,
   output logic [lg_els_lp-1:0]           node_id_o,
   output logic                           data_not_reset_o,
   output logic [lg_width_p-1:0]          len_o,
   output logic [max_payload_width_p-1:0] payload_o,
   output logic                           error_o,
   output logic                           overflow_o
);

   // One counter serves both header fields, so it is as wide as the wider one.
   localparam int cnt_width_lp = (lg_els_lp > lg_width_p) ? lg_els_lp : lg_width_p;

   localparam logic [cnt_width_lp-1:0] cnt_zero_lp = {cnt_width_lp{1'b0}};
   localparam logic [cnt_width_lp-1:0] cnt_one_lp  = cnt_width_lp'(1);
   localparam logic [cnt_width_lp-1:0] node_last_lp = cnt_width_lp'(lg_els_lp - 1);
   localparam logic [cnt_width_lp-1:0] len_last_lp  = cnt_width_lp'(lg_width_p - 1);

   localparam logic [lg_width_p-1:0] len_zero_lp = {lg_width_p{1'b0}};
   localparam logic [lg_width_p-1:0] len_one_lp  = lg_width_p'(1);

   localparam logic [lg_els_lp-1:0]           node_zero_lp = {lg_els_lp{1'b0}};
   localparam logic [max_payload_width_p-1:0] pay_zero_lp  = {max_payload_width_p{1'b0}};

`ifdef BSG_TAG_PACKET_DECODER_PARITY_EN
   localparam int parity_width_lp = lg_els_lp + 1 + lg_width_p + max_payload_width_p;

   // Even parity: the XOR of the covered bits is the parity bit to send.
   function automatic logic even_parity(input logic [parity_width_lp-1:0] bits_i);
      return ^bits_i;
   endfunction

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_NODE    = 3'd1,
      S_DNR     = 3'd2,
      S_LEN     = 3'd3,
      S_PAYLOAD = 3'd4,
      S_PARITY  = 3'd5
   } state_e;
`else
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_NODE    = 3'd1,
      S_DNR     = 3'd2,
      S_LEN     = 3'd3,
      S_PAYLOAD = 3'd4
   } state_e;
`endif

   // Receive FSM and shadow packet
   state_e                          state_q,   state_d;
   logic [cnt_width_lp-1:0]         cnt_q,     cnt_d;
   logic [lg_width_p-1:0]           pay_cnt_q, pay_cnt_d;
   logic [lg_els_lp-1:0]            node_sh_q, node_sh_d;
   logic                            dnr_sh_q,  dnr_sh_d;
   logic [lg_width_p-1:0]           len_sh_q,  len_sh_d;
   logic [max_payload_width_p-1:0]  pay_sh_q,  pay_sh_d;
   logic                            done_q,    done_d;
`ifdef BSG_TAG_PACKET_DECODER_PARITY_EN
   logic                            par_sh_q,  par_sh_d;
`endif

   // Output register
   logic                            valid_q,   valid_d;
   logic [lg_els_lp-1:0]            node_q,    node_d;
   logic                            dnr_q,     dnr_d;
   logic [lg_width_p-1:0]           len_q,     len_d;
   logic [max_payload_width_p-1:0]  payload_q, payload_d;
   logic                            error_q,   error_d;
   logic                            overflow_q, overflow_d;

   // Helper terms
   logic [lg_width_p-1:0]           len_final_s;
   logic [max_payload_width_p-1:0]  pay_bit_s;
   logic                            pay_last_s;
   logic                            oversize_s;
   logic                            parity_bad_s;

   // Field-assembly helpers for the current sample
   always_comb begin
      // len as it will be once the current bit is shifted in (LSB first)
      len_final_s = {data_i, len_sh_q[lg_width_p-1:1]};
      // Payload bit k lands at shadow bit k; indices past the register fall off.
      pay_bit_s   = {{(max_payload_width_p-1){1'b0}}, data_i} << pay_cnt_q;
      pay_last_s  = (pay_cnt_q == (len_sh_q - len_one_lp));
      oversize_s  = ({{(32-lg_width_p){1'b0}}, len_sh_q} > 32'(max_payload_width_p));
`ifdef BSG_TAG_PACKET_DECODER_PARITY_EN
      parity_bad_s = (even_parity({node_sh_q, dnr_sh_q, len_sh_q, pay_sh_q}) != par_sh_q);
`else
      parity_bad_s = 1'b0;
`endif
   end

   // Receive FSM next-state: walk the serial fields into the shadow packet
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pay_cnt_d = pay_cnt_q;
      node_sh_d = node_sh_q;
      dnr_sh_d  = dnr_sh_q;
      len_sh_d  = len_sh_q;
      pay_sh_d  = pay_sh_q;
      done_d    = 1'b0;
`ifdef BSG_TAG_PACKET_DECODER_PARITY_EN
      par_sh_d  = par_sh_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (data_i) begin
               // Start bit: clear the shadow so short payloads read zero above len.
               state_d   = S_NODE;
               cnt_d     = cnt_zero_lp;
               pay_cnt_d = len_zero_lp;
               node_sh_d = node_zero_lp;
               dnr_sh_d  = 1'b0;
               len_sh_d  = len_zero_lp;
               pay_sh_d  = pay_zero_lp;
`ifdef BSG_TAG_PACKET_DECODER_PARITY_EN
               par_sh_d  = 1'b0;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end

         S_NODE: begin
            node_sh_d = {data_i, node_sh_q[lg_els_lp-1:1]};
            if (cnt_q == node_last_lp) begin
               cnt_d   = cnt_zero_lp;
               state_d = S_DNR;
            end else begin
               cnt_d   = cnt_q + cnt_one_lp;
            end
         end

         S_DNR: begin
            dnr_sh_d = data_i;
            state_d  = S_LEN;
         end

         S_LEN: begin
            len_sh_d = len_final_s;
            if (cnt_q == len_last_lp) begin
               cnt_d = cnt_zero_lp;
               if (len_final_s == len_zero_lp) begin
`ifdef BSG_TAG_PACKET_DECODER_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_IDLE;
                  done_d  = 1'b1;
`endif
               end else begin
                  state_d   = S_PAYLOAD;
                  pay_cnt_d = len_zero_lp;
               end
            end else begin
               cnt_d = cnt_q + cnt_one_lp;
            end
         end

         S_PAYLOAD: begin
            pay_sh_d = pay_sh_q | pay_bit_s;
            if (pay_last_s) begin
               pay_cnt_d = len_zero_lp;
`ifdef BSG_TAG_PACKET_DECODER_PARITY_EN
               state_d   = S_PARITY;
`else
               state_d   = S_IDLE;
               done_d    = 1'b1;
`endif
            end else begin
               pay_cnt_d = pay_cnt_q + len_one_lp;
            end
         end

`ifdef BSG_TAG_PACKET_DECODER_PARITY_EN
         S_PARITY: begin
            par_sh_d = data_i;
            state_d  = S_IDLE;
            done_d   = 1'b1;
         end
`endif

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Receive FSM state and shadow registers
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= cnt_zero_lp;
         pay_cnt_q <= len_zero_lp;
         node_sh_q <= node_zero_lp;
         dnr_sh_q  <= 1'b0;
         len_sh_q  <= len_zero_lp;
         pay_sh_q  <= pay_zero_lp;
         done_q    <= 1'b0;
`ifdef BSG_TAG_PACKET_DECODER_PARITY_EN
         par_sh_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pay_cnt_q <= pay_cnt_d;
         node_sh_q <= node_sh_d;
         dnr_sh_q  <= dnr_sh_d;
         len_sh_q  <= len_sh_d;
         pay_sh_q  <= pay_sh_d;
         done_q    <= done_d;
`ifdef BSG_TAG_PACKET_DECODER_PARITY_EN
         par_sh_q  <= par_sh_d;
`endif
      end
   end

   // Completion classification and valid/yumi handshake
   always_comb begin
      valid_d    = valid_q;
      node_d     = node_q;
      dnr_d      = dnr_q;
      len_d      = len_q;
      payload_d  = payload_q;
      error_d    = 1'b0;
      overflow_d = 1'b0;

      if (valid_q && yumi_i) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end

      // done_q marks the cycle after the last bit; the shadow is still intact
      // here even if the next start bit is being accepted in the same cycle.
      if (done_q) begin
         if (oversize_s) begin
            error_d = 1'b1;
         end else if (parity_bad_s) begin
            error_d = 1'b1;
         end else if (!valid_q || yumi_i) begin
            valid_d   = 1'b1;
            node_d    = node_sh_q;
            dnr_d     = dnr_sh_q;
            len_d     = len_sh_q;
            payload_d = pay_sh_q;
         end else begin
            overflow_d = 1'b1;
         end
      end else begin
         error_d    = 1'b0;
         overflow_d = 1'b0;
      end
   end

   // Output register
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         valid_q    <= 1'b0;
         node_q     <= node_zero_lp;
         dnr_q      <= 1'b0;
         len_q      <= len_zero_lp;
         payload_q  <= pay_zero_lp;
         error_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         node_q     <= node_d;
         dnr_q      <= dnr_d;
         len_q      <= len_d;
         payload_q  <= payload_d;
         error_q    <= error_d;
         overflow_q <= overflow_d;
      end
   end

   assign valid_o          = valid_q;
   assign node_id_o        = node_q;
   assign data_not_reset_o = dnr_q;
   assign len_o            = len_q;
   assign payload_o        = payload_q;
   assign error_o          = error_q;
   assign overflow_o       = overflow_q;

endmodule

// File: tb/tb_bsg_tag_packet_decoder.sv
module tb_bsg_tag_packet_decoder;

   logic       clk = 1'b0;
   logic       reset_i = 1'b1;
   logic       data_i = 1'b0;
   logic       yumi_i = 1'b0;
   logic       valid_o;
   logic [5:0] node_id_o;
   logic       data_not_reset_o;
   logic [3:0] len_o;
   logic [9:0] payload_o;
   logic       error_o;
   logic       overflow_o;

   bsg_tag_packet_decoder #(
      .els_p(64),
      .lg_width_p(4),
      .max_payload_width_p(10)
   ) dut (
      .clk_i(clk),
      .reset_i(reset_i),
      .data_i(data_i),
      .valid_o(valid_o),
      .yumi_i(yumi_i),
      .node_id_o(node_id_o),
      .data_not_reset_o(data_not_reset_o),
      .len_o(len_o),
      .payload_o(payload_o),
      .error_o(error_o),
      .overflow_o(overflow_o)
   );

   always #5 clk = ~clk;

   typedef enum logic [1:0] {K_ACCEPT = 2'd0, K_ERROR = 2'd1, K_OVERFLOW = 2'd2} kind_e;

   typedef struct packed {
      logic [31:0] due;
      kind_e       kind;
      logic        valid;
      logic [5:0]  node;
      logic        dnr;
      logic [3:0]  len;
      logic [9:0]  payload;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   logic [31:0] cyc = 32'd0;
`ifdef BSG_TAG_PACKET_DECODER_PARITY_EN
   logic        flip_parity = 1'b0;
`endif

   always @(posedge clk) cyc <= cyc + 32'd1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input kind_e k, input logic v, input logic [5:0] nd,
                               input logic d, input logic [3:0] l, input logic [9:0] p);
      exp_t e;
      e.due = 32'd0; e.kind = k; e.valid = v; e.node = nd; e.dnr = d; e.len = l; e.payload = p;
      return e;
   endfunction

   // Serialise one packet, LSB first, with parity when configured.
   task automatic build(input logic [5:0] node, input logic dnr, input logic [3:0] len,
                        input logic [15:0] payload, output logic [39:0] bits, output int n);
      bits = 40'd0;
      n = 0;
      bits[n] = 1'b1; n++;
      for (int i = 0; i < 6; i++) begin bits[n] = node[i]; n++; end
      bits[n] = dnr; n++;
      for (int i = 0; i < 4; i++) begin bits[n] = len[i]; n++; end
      for (int i = 0; i < int'(len); i++) begin bits[n] = payload[i]; n++; end
`ifdef BSG_TAG_PACKET_DECODER_PARITY_EN
      begin
         logic par;
         par = ^{node, dnr, len};
         for (int i = 0; i < int'(len); i++) par = par ^ payload[i];
         bits[n] = par ^ flip_parity; n++;
      end
`endif
   endtask

   // Drive bits on negedges; the outcome is due two edges after the last bit.
   task automatic drive(input logic [39:0] bits, input int n, input logic push, input exp_t e);
      exp_t t;
      t = e;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         data_i = bits[i];
         if (push && (i == n - 1)) begin
            t.due = cyc + 32'd2;
            sb.push_back(t);
         end
      end
   endtask

   task automatic send(input logic [5:0] node, input logic dnr, input logic [3:0] len,
                       input logic [15:0] payload, input exp_t e);
      logic [39:0] bits;
      int n;
      build(node, dnr, len, payload, bits, n);
      drive(bits, n, 1'b1, e);
   endtask

   // Completion cycle, then land on the negedge where outputs are checked.
   task automatic finish_pkt();
      @(negedge clk);
      data_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic take();
      yumi_i = 1'b1;
      @(negedge clk);
      yumi_i = 1'b0;
      check("valid_after_yumi", {31'd0, valid_o}, 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"},   {31'd0, valid_o}, 32'd0);
      check({tag, "_node"},    {26'd0, node_id_o}, 32'd0);
      check({tag, "_dnr"},     {31'd0, data_not_reset_o}, 32'd0);
      check({tag, "_len"},     {28'd0, len_o}, 32'd0);
      check({tag, "_payload"}, {22'd0, payload_o}, 32'd0);
      check({tag, "_error"},   {31'd0, error_o}, 32'd0);
      check({tag, "_overflow"}, {31'd0, overflow_o}, 32'd0);
   endtask

   // Scoreboard monitor: pop expectations when due, else expect no pulses.
   always @(negedge clk) begin
      if (sb.size() != 0 && sb[0].due == cyc) begin
         exp_t e;
         e = sb.pop_front();
         case (e.kind)
            K_ACCEPT: begin
               check("acc_valid",   {31'd0, valid_o}, 32'd1);
               check("acc_node",    {26'd0, node_id_o}, {26'd0, e.node});
               check("acc_dnr",     {31'd0, data_not_reset_o}, {31'd0, e.dnr});
               check("acc_len",     {28'd0, len_o}, {28'd0, e.len});
               check("acc_payload", {22'd0, payload_o}, {22'd0, e.payload});
               check("acc_error",   {31'd0, error_o}, 32'd0);
               check("acc_overflow", {31'd0, overflow_o}, 32'd0);
            end
            K_ERROR: begin
               check("err_error",    {31'd0, error_o}, 32'd1);
               check("err_overflow", {31'd0, overflow_o}, 32'd0);
               check("err_valid",    {31'd0, valid_o}, {31'd0, e.valid});
            end
            default: begin
               check("ovf_overflow", {31'd0, overflow_o}, 32'd1);
               check("ovf_error",    {31'd0, error_o}, 32'd0);
               check("ovf_valid",    {31'd0, valid_o}, 32'd1);
               check("ovf_node",     {26'd0, node_id_o}, {26'd0, e.node});
            end
         endcase
      end else begin
         check("idle_error",    {31'd0, error_o}, 32'd0);
         check("idle_overflow", {31'd0, overflow_o}, 32'd0);
      end
   end

   initial begin
      logic [39:0] pbits;
      int          pn;

      // Reset state
      @(negedge clk);
      check_all_zero("reset");
      @(negedge clk);
      reset_i = 1'b0;
      repeat (2) @(negedge clk);

      // Basic packet: node 5, dnr 1, len 3, payload 101
      send(6'd5, 1'b1, 4'd3, 16'h0005, mk(K_ACCEPT, 1'b1, 6'd5, 1'b1, 4'd3, 10'h005));
      @(negedge clk);
      data_i = 1'b0;
      check("basic_not_early", {31'd0, valid_o}, 32'd0);
      @(negedge clk);
      take();

      // Zero-length client reset packet
      send(6'd63, 1'b0, 4'd0, 16'h0000, mk(K_ACCEPT, 1'b1, 6'd63, 1'b0, 4'd0, 10'h000));
      @(negedge clk);
      data_i = 1'b0;
      check("zero_len_not_early", {31'd0, valid_o}, 32'd0);
      @(negedge clk);
      take();

      // Oversize packet then a good one
      send(6'd9, 1'b1, 4'd12, 16'h0ABC, mk(K_ERROR, 1'b0, 6'd0, 1'b0, 4'd0, 10'h000));
      finish_pkt();
      check("oversize_no_valid", {31'd0, valid_o}, 32'd0);
      send(6'd1, 1'b1, 4'd1, 16'h0001, mk(K_ACCEPT, 1'b1, 6'd1, 1'b1, 4'd1, 10'h001));
      finish_pkt();
      take();

      // Full output register, back-to-back, no yumi
      send(6'd2, 1'b1, 4'd2, 16'h0002, mk(K_ACCEPT, 1'b1, 6'd2, 1'b1, 4'd2, 10'h002));
      send(6'd3, 1'b1, 4'd1, 16'h0001, mk(K_OVERFLOW, 1'b1, 6'd2, 1'b1, 4'd2, 10'h002));
      finish_pkt();
      check("full_held_node", {26'd0, node_id_o}, 32'd2);
      check("full_held_payload", {22'd0, payload_o}, 32'd2);
      take();

      // Same again with yumi on node 3's completion cycle
      send(6'd2, 1'b1, 4'd2, 16'h0002, mk(K_ACCEPT, 1'b1, 6'd2, 1'b1, 4'd2, 10'h002));
      send(6'd3, 1'b1, 4'd1, 16'h0001, mk(K_ACCEPT, 1'b1, 6'd3, 1'b1, 4'd1, 10'h001));
      @(negedge clk);
      data_i = 1'b0;
      yumi_i = 1'b1;
      @(negedge clk);
      yumi_i = 1'b0;
      check("reload_valid", {31'd0, valid_o}, 32'd1);
      check("reload_node", {26'd0, node_id_o}, 32'd3);
      take();

      // Reset in the middle of a packet's LEN field, with a packet held
      send(6'd4, 1'b1, 4'd1, 16'h0001, mk(K_ACCEPT, 1'b1, 6'd4, 1'b1, 4'd1, 10'h001));
      finish_pkt();
      build(6'd9, 1'b1, 4'd5, 16'h001F, pbits, pn);
      drive(pbits, 10, 1'b0, mk(K_ACCEPT, 1'b0, 6'd0, 1'b0, 4'd0, 10'h000));
      #2;
      reset_i = 1'b1;
      #1;
      check_all_zero("mid_reset");
      data_i = 1'b0;
      repeat (2) @(negedge clk);
      reset_i = 1'b0;
      @(negedge clk);
      send(6'd7, 1'b1, 4'd2, 16'h0003, mk(K_ACCEPT, 1'b1, 6'd7, 1'b1, 4'd2, 10'h003));
      finish_pkt();
      check("post_reset_payload", {22'd0, payload_o}, 32'd3);
      take();

`ifdef BSG_TAG_PACKET_DECODER_PARITY_EN
      // Parity good, then parity flipped
      send(6'd5, 1'b1, 4'd3, 16'h0005, mk(K_ACCEPT, 1'b1, 6'd5, 1'b1, 4'd3, 10'h005));
      finish_pkt();
      take();
      flip_parity = 1'b1;
      send(6'd5, 1'b1, 4'd3, 16'h0005, mk(K_ERROR, 1'b0, 6'd0, 1'b0, 4'd0, 10'h000));
      flip_parity = 1'b0;
      finish_pkt();
      check("parity_bad_no_valid", {31'd0, valid_o}, 32'd0);
`endif

      repeat (4) @(negedge clk);
      check("scoreboard_drained", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
